uart8_tx_queue: RTL and testbench

Byte queue and launch sequencer that sits directly upstream of the UART transmitter's tx interface (txStart / txIn / txBusy). Host logic writes bytes at board-clock rate. The block buffers them in a FIFO and hands them one at a time to the transmitter, which runs on the slower baud-derived clock. It holds each handshake level until the transmitter acknowledges it, so no start request is lost across the rate difference.

---
 rtl/uart8_tx_queue.sv | 131 +++++++++++++
 tb/tb_uart8_tx_queue.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart8_tx_queue.sv
// uart8_tx_queue: byte FIFO and launch sequencer feeding a UART tx port.
// Each txStart is held until the slower transmitter reports busy.
module uart8_tx_queue #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  wrEn,
  input  logic [7:0]            wrData,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  ovfClr,
  output logic                  idle,
  output logic [15:0]           sentCount,
  output logic                  txStart,
  output logic [7:0]            txIn,
  input  logic                  txBusy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] CMAX = CW'(DEPTH);
  localparam logic [CW-1:0] CONE = CW'(1);
  localparam logic [DEPTH_LOG2-1:0] PONE = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT
  } stateT;

  stateT state;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr;
  logic [DEPTH_LOG2-1:0] rdPtr;
  logic [CW-1:0]         countNext;
  logic                  pop;
  logic                  wrOk;
  logic                  drop;

  // A pop frees a slot in the same cycle, so a write to a full queue can still land
  assign pop  = (state == IDLE) && en && !empty;
  assign wrOk = wrEn && (!full || pop);
  assign drop = wrEn && !wrOk;
  assign idle = (state == IDLE) && empty;

  // Next occupancy from the accepted write and the pop of this cycle
  always_comb begin
    countNext = count;
    if (wrOk && !pop) begin
      countNext = count + CONE;
    end else if (pop && !wrOk) begin
      countNext = count - CONE;
    end
  end

  // Storage array; contents are don't-care while not counted
  always_ff @(posedge clk) begin
    if (wrOk) begin
      mem[wrPtr] <= wrData;
    end
  end

  // Pointers, occupancy flags and the sticky overflow bit
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (wrOk) begin
        wrPtr <= wrPtr + PONE;
      end
      if (pop) begin
        rdPtr <= rdPtr + PONE;
      end
      count <= countNext;
      full  <= (countNext == CMAX);
      empty <= (countNext == '0);
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovfClr) begin
        overflow <= 1'b0;
      end
    end
  end

  // Launch sequencer: pop, hold txStart until busy, then wait for busy to clear
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      txStart   <= 1'b0;
      txIn      <= 8'h00;
      sentCount <= 16'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            txIn    <= mem[rdPtr];
            txStart <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (txBusy) begin
            txStart <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (!txBusy) begin
            sentCount <= sentCount + 16'd1;
            state     <= IDLE;
          end
        end
        default: begin
          txStart <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart8_tx_queue.sv
// tb_uart8_tx_queue: directed checks of the tx byte queue
// with a behavioural transmitter raising txBusy 3 cycles after txStart.
module tb_uart8_tx_queue;

  localparam int DL = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          wrEn;
  logic [7:0]    wrData;
  logic          full;
  logic          empty;
  logic [DL:0]   count;
  logic          overflow;
  logic          ovfClr;
  logic          idle;
  logic [15:0]   sentCount;
  logic          txStart;
  logic [7:0]    txIn;
  logic          txBusy;

  uart8_tx_queue #(.DEPTH_LOG2(DL)) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .wrEn(wrEn),
    .wrData(wrData),
    .full(full),
    .empty(empty),
    .count(count),
    .overflow(overflow),
    .ovfClr(ovfClr),
    .idle(idle),
    .sentCount(sentCount),
    .txStart(txStart),
    .txIn(txIn),
    .txBusy(txBusy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int phase = 0;
  int cnt = 0;
  logic [7:0] seen[$];

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       clr;
    logic [2:0] c;
    logic       f;
    logic       o;
  } vecT;

  vecT tbl[10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // one clock; the transmitter model reacts just after the edge
  task automatic step();
    @(posedge clk);
    #1;
    case (phase)
      0: if (txStart) begin
        seen.push_back(txIn);
        cnt = 3;
        phase = 1;
      end
      1: begin
        cnt--;
        if (cnt == 0) begin
          txBusy = 1'b1;
          cnt = 20;
          phase = 2;
        end
      end
      2: begin
        cnt--;
        if (cnt == 0) begin
          txBusy = 1'b0;
          phase = 0;
        end
      end
      default: phase = 0;
    endcase
  endtask

  task automatic waitIdle(input int maxc);
    for (int i = 0; i < maxc && !(idle && phase == 0); i++) step();
  endtask

  task automatic doReset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic chkSeen(input string name, input logic [7:0] exp [],
                         input int n);
    chk({name, "_n"}, 32'(seen.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < seen.size()) chk(name, 32'(seen[i]), 32'(exp[i]));
    end
  endtask

  initial begin
    logic [2:0] peak;
    int bad;
    logic [7:0] expb [];

    tbl[0] = '{1'b1, 8'hA0, 1'b0, 3'd1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'hA1, 1'b0, 3'd2, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'hA2, 1'b0, 3'd3, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 8'hA3, 1'b0, 3'd4, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 8'hA4, 1'b0, 3'd4, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 8'hA5, 1'b0, 3'd4, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 3'd4, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 8'hA6, 1'b1, 3'd4, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 3'd4, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 3'd4, 1'b1, 1'b0};

    reset = 1'b1;
    en = 1'b0;
    wrEn = 1'b0;
    wrData = 8'h00;
    ovfClr = 1'b0;
    txBusy = 1'b0;

    // reset values
    step();
    step();
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_sent", 32'(sentCount), 32'd0);
    chk("rst_txStart", 32'(txStart), 32'd0);
    chk("rst_txIn", 32'(txIn), 32'd0);
    reset = 1'b0;

    // single byte latency and handshake
    en = 1'b1;
    wrEn = 1'b1;
    wrData = 8'hA5;
    step();
    wrEn = 1'b0;
    chk("one_empty_c1", 32'(empty), 32'd0);
    chk("one_txStart_c1", 32'(txStart), 32'd0);
    step();
    chk("one_txStart_c2", 32'(txStart), 32'd1);
    chk("one_txIn_c2", 32'(txIn), 32'hA5);
    for (int k = 3; k <= 6; k++) begin
      step();
      chk("one_txStart_hold", 32'(txStart), (k < 6) ? 32'd1 : 32'd0);
    end
    waitIdle(200);
    chk("one_idle", 32'(idle), 32'd1);
    chk("one_sent", 32'(sentCount), 32'd1);
    chk("one_txIn_keep", 32'(txIn), 32'hA5);
    expb = new[1];
    expb[0] = 8'hA5;
    chkSeen("one_seen", expb, 1);

    // burst order and count peak
    doReset();
    seen.delete();
    peak = '0;
    for (int i = 0; i < 5; i++) begin
      wrEn = 1'b1;
      wrData = 8'(i + 1);
      step();
      if (count > peak) peak = count;
    end
    wrEn = 1'b0;
    for (int i = 0; i < 400 && !(idle && phase == 0); i++) begin
      step();
      if (count > peak) peak = count;
    end
    chk("burst_peak", 32'(peak), 32'd4);
    chk("burst_ovf", 32'(overflow), 32'd0);
    chk("burst_sent", 32'(sentCount), 32'd5);
    expb = new[5];
    for (int i = 0; i < 5; i++) expb[i] = 8'(i + 1);
    chkSeen("burst_seen", expb, 5);

    // overflow table with launches disabled
    doReset();
    seen.delete();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wrEn = tbl[i].wr;
      wrData = tbl[i].d;
      ovfClr = tbl[i].clr;
      step();
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].c));
      chk($sformatf("tbl%0d_full", i), 32'(full), 32'(tbl[i].f));
      chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].c == 3'd0));
      chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].o));
    end
    wrEn = 1'b0;
    ovfClr = 1'b0;

    // full plus pop: write in the pop cycle is accepted
    en = 1'b1;
    wrEn = 1'b1;
    wrData = 8'hB0;
    step();
    wrEn = 1'b0;
    chk("fp_count", 32'(count), 32'd4);
    chk("fp_full", 32'(full), 32'd1);
    chk("fp_ovf", 32'(overflow), 32'd0);
    waitIdle(400);
    chk("fp_sent", 32'(sentCount), 32'd5);
    expb = new[5];
    expb[0] = 8'hA0;
    expb[1] = 8'hA1;
    expb[2] = 8'hA2;
    expb[3] = 8'hA3;
    expb[4] = 8'hB0;
    chkSeen("fp_seen", expb, 5);

    // en gating while in WAIT
    seen.delete();
    wrEn = 1'b1;
    wrData = 8'hC1;
    step();
    wrData = 8'hC2;
    step();
    wrEn = 1'b0;
    for (int i = 0; i < 100 && !(seen.size() == 1 && !txStart); i++) step();
    en = 1'b0;
    for (int i = 0; i < 200 && sentCount != 16'd6; i++) step();
    chk("en_sent", 32'(sentCount), 32'd6);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (txStart) bad++;
    end
    chk("en_noStart", 32'(bad), 32'd0);
    chk("en_count", 32'(count), 32'd1);
    en = 1'b1;
    step();
    chk("en_resume", 32'(txStart), 32'd1);
    chk("en_resumeData", 32'(txIn), 32'hC2);
    waitIdle(200);
    chk("en_sent2", 32'(sentCount), 32'd7);

    // reset while in START with 3 bytes queued
    doReset();
    seen.delete();
    for (int i = 0; i < 4; i++) begin
      wrEn = 1'b1;
      wrData = 8'(8'hD1 + i);
      step();
    end
    wrEn = 1'b0;
    chk("mr_countPre", 32'(count), 32'd3);
    chk("mr_startPre", 32'(txStart), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_txStart", 32'(txStart), 32'd0);
    chk("mr_count", 32'(count), 32'd0);
    chk("mr_empty", 32'(empty), 32'd1);
    chk("mr_sent", 32'(sentCount), 32'd0);
    for (int i = 0; i < 100 && !(phase == 0 && !txBusy); i++) step();
    chk("mr_notCounted", 32'(sentCount), 32'd0);
    seen.delete();
    wrEn = 1'b1;
    wrData = 8'hE7;
    step();
    wrEn = 1'b0;
    waitIdle(200);
    chk("mr_sentAfter", 32'(sentCount), 32'd1);
    expb = new[1];
    expb[0] = 8'hE7;
    chkSeen("mr_seen", expb, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
